// File: rtl/apu_envelope_length.sv
// apu_envelope_length
// Per-channel envelope generator and length counter for the APU pulse and
// noise channels. It sits downstream of the frame counter. The quarter-frame
// pulse clocks the envelope and the half-frame pulse clocks the length counter.
// Outputs are the channel volume and the length-active status.
//
// Optional build macro: APU_LEN_RELOAD_QUIRK_EN
//   When defined, a length write that lands in the same cycle as a real
//   half-frame decrement is dropped, as on the 2A03. The start flag is still
//   set. When undefined, the load always wins.

module apu_envelope_length #(
  parameter bit MUTE_ON_ZERO_LEN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qtrframe,
  input  logic       halfframe,
  input  logic       enable,
  input  logic       wr_ctrl,
  input  logic       wr_len,
  input  logic [7:0] wdata,
  output logic [3:0] volume,
  output logic       len_active,
  output logic [7:0] len_count
);

  logic       halt_loop;
  logic       const_vol;
  logic [3:0] vol_per;
  logic       start;
  logic [3:0] divider;
  logic [3:0] decay;

  logic       len_decrement;
  logic       len_load;
  logic [7:0] len_table_value;

  // Length load value lookup, indexed by the top five bits of the write.
  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    logic [7:0] value;
    case (idx)
      5'd0:    value = 8'd10;
      5'd1:    value = 8'd254;
      5'd2:    value = 8'd20;
      5'd3:    value = 8'd2;
      5'd4:    value = 8'd40;
      5'd5:    value = 8'd4;
      5'd6:    value = 8'd80;
      5'd7:    value = 8'd6;
      5'd8:    value = 8'd160;
      5'd9:    value = 8'd8;
      5'd10:   value = 8'd60;
      5'd11:   value = 8'd10;
      5'd12:   value = 8'd14;
      5'd13:   value = 8'd12;
      5'd14:   value = 8'd26;
      5'd15:   value = 8'd14;
      5'd16:   value = 8'd12;
      5'd17:   value = 8'd16;
      5'd18:   value = 8'd24;
      5'd19:   value = 8'd18;
      5'd20:   value = 8'd48;
      5'd21:   value = 8'd20;
      5'd22:   value = 8'd96;
      5'd23:   value = 8'd22;
      5'd24:   value = 8'd192;
      5'd25:   value = 8'd24;
      5'd26:   value = 8'd72;
      5'd27:   value = 8'd26;
      5'd28:   value = 8'd16;
      5'd29:   value = 8'd28;
      5'd30:   value = 8'd32;
      default: value = 8'd30;
    endcase
    return value;
  endfunction

  // Control register: loop/halt flag, constant-volume flag and volume/period.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_loop <= 1'b0;
      const_vol <= 1'b0;
      vol_per   <= 4'd0;
    end else if (wr_ctrl) begin
      halt_loop <= wdata[5];
      const_vol <= wdata[4];
      vol_per   <= wdata[3:0];
    end
  end

  // Envelope: the start flag restarts the decay at 15; otherwise the divider
  // counts down from the period and steps the decay each time it expires.
  // A length write arms start last, so it survives a coincident quarter frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      start   <= 1'b0;
      divider <= 4'd0;
      decay   <= 4'd0;
    end else begin
      if (qtrframe) begin
        if (start) begin
          start   <= 1'b0;
          decay   <= 4'd15;
          divider <= vol_per;
        end else if (divider == 4'd0) begin
          divider <= vol_per;
          if (decay != 4'd0) begin
            decay <= decay - 4'd1;
          end else if (halt_loop) begin
            decay <= 4'd15;
          end
        end else begin
          divider <= divider - 4'd1;
        end
      end
      if (wr_len) begin
        start <= 1'b1;
      end
    end
  end

  // Decide between a table load and a half-frame decrement for this cycle.
  always_comb begin
    len_table_value = len_lookup(wdata[7:3]);
    len_decrement   = halfframe && !halt_loop && (len_count != 8'd0);
`ifdef APU_LEN_RELOAD_QUIRK_EN
    len_load        = wr_len && enable && !len_decrement;
`else
    len_load        = wr_len && enable;
`endif
  end

  // Length counter: held at zero while the channel is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_count <= 8'd0;
    end else if (!enable) begin
      len_count <= 8'd0;
    end else if (len_load) begin
      len_count <= len_table_value;
    end else if (len_decrement) begin
      len_count <= len_count - 8'd1;
    end
  end

  // Output volume selects constant or decay level, muted when length is spent.
  always_comb begin
    volume = const_vol ? vol_per : decay;
    if (MUTE_ON_ZERO_LEN && (len_count == 8'd0)) begin
      volume = 4'd0;
    end
  end

  assign len_active = |len_count;

endmodule

// File: tb/tb_apu_envelope_length.sv
// tb_apu_envelope_length
// Directed bench for apu_envelope_length. A behavioural model of the channel
// tracks every cycle, and a negedge process compares it with the DUT. Literal
// checks at key points pin the model to hand-computed values.
// Honours APU_LEN_RELOAD_QUIRK_EN for the collision expectation.

module tb_apu_envelope_length;

  logic       clk;
  logic       rst;
  logic       qtrframe;
  logic       halfframe;
  logic       enable;
  logic       wr_ctrl;
  logic       wr_len;
  logic [7:0] wdata;
  logic [3:0] volume;
  logic       len_active;
  logic [7:0] len_count;

  int tests_run;
  int tests_failed;
  bit check_en;

  localparam bit MUTE = 1'b1;

  int len_table [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                         12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Behavioural model state.
  int m_halt, m_const, m_per, m_start, m_div, m_decay, m_len;
  bit m_dec, m_load;

  apu_envelope_length dut (
    .clk       (clk),
    .rst       (rst),
    .qtrframe  (qtrframe),
    .halfframe (halfframe),
    .enable    (enable),
    .wr_ctrl   (wr_ctrl),
    .wr_len    (wr_len),
    .wdata     (wdata),
    .volume    (volume),
    .len_active(len_active),
    .len_count (len_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_volume();
    if (MUTE && m_len == 0) return 0;
    return (m_const != 0) ? m_per : m_decay;
  endfunction

  // Model advances on each rising edge from the inputs held since the last negedge.
  always @(posedge clk) begin
    if (rst) begin
      m_halt = 0; m_const = 0; m_per = 0; m_start = 0;
      m_div = 0; m_decay = 0; m_len = 0;
    end else begin
      m_dec  = halfframe && (m_halt == 0) && (m_len > 0);
      m_load = wr_len && enable;
`ifdef APU_LEN_RELOAD_QUIRK_EN
      if (m_dec) m_load = 1'b0;
`endif
      if (!enable) m_len = 0;
      else if (m_load) m_len = len_table[wdata[7:3]];
      else if (m_dec) m_len = m_len - 1;

      if (qtrframe) begin
        if (m_start != 0) begin
          m_start = 0; m_decay = 15; m_div = m_per;
        end else if (m_div == 0) begin
          m_div = m_per;
          if (m_decay > 0) m_decay = m_decay - 1;
          else if (m_halt != 0) m_decay = 15;
        end else begin
          m_div = m_div - 1;
        end
      end
      if (wr_len) m_start = 1;

      if (wr_ctrl) begin
        m_halt  = int'(wdata[5]);
        m_const = int'(wdata[4]);
        m_per   = int'(wdata[3:0]);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      tests_run++;
      if (int'(volume) != model_volume()) begin
        tests_failed++;
        $display("[TB] FAIL model_volume t=%0t got %0d want %0d", $time, volume, model_volume());
      end
      tests_run++;
      if (int'(len_count) != m_len) begin
        tests_failed++;
        $display("[TB] FAIL model_len_count t=%0t got %0d want %0d", $time, len_count, m_len);
      end
      tests_run++;
      if (len_active != (m_len != 0)) begin
        tests_failed++;
        $display("[TB] FAIL model_len_active t=%0t got %0d want %0d", $time, len_active, (m_len != 0));
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; strobes drop after the rising edge.
  task automatic applyStimulus(input logic q, input logic h, input logic wc,
                               input logic wl, input logic [7:0] wd);
    @(negedge clk);
    qtrframe  = q;
    halfframe = h;
    wr_ctrl   = wc;
    wr_len    = wl;
    wdata     = wd;
    @(posedge clk);
    #1;
    qtrframe  = 1'b0;
    halfframe = 1'b0;
    wr_ctrl   = 1'b0;
    wr_len    = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    check_en = 1'b0;
    rst = 1'b1;
    qtrframe = 1'b0; halfframe = 1'b0; enable = 1'b0;
    wr_ctrl = 1'b0; wr_len = 1'b0; wdata = 8'h00;

    // Reset, held through the first edges.
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;
    checkOutput("reset_volume", int'(volume), 0);
    checkOutput("reset_len_count", int'(len_count), 0);
    checkOutput("reset_len_active", int'(len_active), 0);

    // Load length from index 1, then three half frames.
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
    checkOutput("load_idx1", int'(len_count), 254);
    checkOutput("load_active", int'(len_active), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("three_half", int'(len_count), 251);

    // Halt freezes the count; a ctrl write with a half frame uses the old halt.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h20);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("halt_hold", int'(len_count), 251);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("ctrl_half_old_halt", int'(len_count), 251);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("unhalted_dec", int'(len_count), 250);

    // Disabling clears the counter and blocks loads.
    enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("disable_clear", int'(len_count), 0);
    checkOutput("disable_inactive", int'(len_active), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
    checkOutput("disabled_load_ignored", int'(len_count), 0);
    enable = 1'b1;

    // Envelope without loop: period 2, decays every third quarter frame.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("env_start", int'(volume), 15);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("env_first_step", int'(volume), 14);
    for (int i = 0; i < 42; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("env_bottom", int'(volume), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("env_hold_zero", int'(volume), 0);

    // Envelope with loop wraps from 0 back to 15.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("loop_start", int'(volume), 15);
    for (int i = 0; i < 45; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("loop_bottom", int'(volume), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("loop_wrap", int'(volume), 15);

    // Constant volume, then mute when length runs out.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h17);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
    checkOutput("const_vol", int'(volume), 7);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("const_vol_after_qtr", int'(volume), 7);
    for (int i = 0; i < 253; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("len_one_left", int'(len_count), 1);
    checkOutput("const_vol_len1", int'(volume), 7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("len_zero", int'(len_count), 0);
    checkOutput("muted_volume", int'(volume), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("len_floor", int'(len_count), 0);

    // Length write colliding with a half-frame decrement.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    checkOutput("load_20", int'(len_count), 20);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h18);
`ifdef APU_LEN_RELOAD_QUIRK_EN
    checkOutput("collision", int'(len_count), 19);
`else
    checkOutput("collision", int'(len_count), 2);
`endif
    // Start flag was armed by the collision write either way.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("collision_start", int'(volume), 15);

    // Mid-operation reset discards everything.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_len", int'(len_count), 0);
    checkOutput("midreset_volume", int'(volume), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("midreset_no_start", int'(volume), 0);

    @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
